operand_sequencer: RTL and testbench



---
 rtl/operand_sequencer_if.sv | 18 +
 rtl/operand_sequencer.sv | 67 ++++++
 tb/tb_operand_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/operand_sequencer_if.sv
// operand_sequencer_if: operand/request inputs and display/status outputs of the sequencer
interface operand_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  parameter int OUT_WIDTH = 16
);
  localparam int PHASE_W = $clog2(CHANNELS + 2);
  logic Start;
  logic Auto;
  logic [CHANNELS*WIDTH-1:0] Data_in;
  logic [OUT_WIDTH-1:0] Data_out;
  logic [PHASE_W-1:0] Phase;
  logic Busy;
  logic Done;
  logic Overflow;
  modport master(output Start, Auto, Data_in, input Data_out, Phase, Busy, Done, Overflow);
  modport slave(input Start, Auto, Data_in, output Data_out, Phase, Busy, Done, Overflow);
endinterface

// File: rtl/operand_sequencer.sv
// operand_sequencer: captures CHANNELS operands, shows each and then their sum for DWELL cycles apiece
module operand_sequencer #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  parameter int OUT_WIDTH = 16,
  parameter int DWELL = 1,
  localparam int PHASE_W = $clog2(CHANNELS + 2)
) (
  input logic Clock,
  input logic Resetn,
  operand_sequencer_if.slave bus
);
  localparam int K_W = $clog2(CHANNELS);
  localparam int D_W = DWELL > 1 ? $clog2(DWELL) : 1;
  typedef enum logic [1:0] {IDLE, SHOW, SUM} state_t;
  state_t state, state_d;
  logic [CHANNELS*WIDTH-1:0] bank, bank_d;
  logic [K_W-1:0] k, k_d;
  logic [D_W-1:0] dw, dw_d;
  logic [OUT_WIDTH-1:0] acc, acc_d, sum, data_d;
  logic [PHASE_W-1:0] phase_d;
  logic ovf, ovf_d, last, carry, cap, busy_d, done_d;
  assign bus.Overflow = ovf;
  // next state plus the output values registered for the coming cycle
  always_comb begin
    last = dw == D_W'(DWELL - 1);
    {carry, sum} = {1'b0, acc} + (OUT_WIDTH + 1)'(bank[k*WIDTH +: WIDTH]);
    cap = state == IDLE ? bus.Start | bus.Auto : state == SUM && last && bus.Auto;
    state_d = cap ? SHOW
            : state == SHOW && last && k == K_W'(CHANNELS - 1) ? SUM
            : state == SUM && last ? IDLE : state;
    k_d = cap ? '0 : state == SHOW && last && k != K_W'(CHANNELS - 1) ? k + 1'b1 : k;
    dw_d = cap || last || state == IDLE ? '0 : dw + 1'b1;
    acc_d = cap ? '0 : state == SHOW && last ? sum : acc;
    ovf_d = cap ? 1'b0 : state == SHOW && last ? ovf | carry : ovf;
    bank_d = cap ? bus.Data_in : bank;
    data_d = state_d == SHOW ? OUT_WIDTH'(bank_d[k_d*WIDTH +: WIDTH]) : state_d == SUM ? acc_d : '0;
    phase_d = state_d == SHOW ? PHASE_W'(k_d) + 1'b1 : state_d == SUM ? PHASE_W'(CHANNELS + 1) : '0;
    busy_d = state_d != IDLE;
    done_d = state_d == SUM && dw_d == D_W'(DWELL - 1);
  end
  // state, datapath and registered outputs; reset aborts any sequence at once
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      state <= IDLE;
      bank <= '0;
      k <= '0;
      dw <= '0;
      acc <= '0;
      ovf <= 1'b0;
      bus.Data_out <= '0;
      bus.Phase <= '0;
      bus.Busy <= 1'b0;
      bus.Done <= 1'b0;
    end else begin
      state <= state_d;
      bank <= bank_d;
      k <= k_d;
      dw <= dw_d;
      acc <= acc_d;
      ovf <= ovf_d;
      bus.Data_out <= data_d;
      bus.Phase <= phase_d;
      bus.Busy <= busy_d;
      bus.Done <= done_d;
    end
endmodule

// File: tb/tb_operand_sequencer.sv
// tb_operand_sequencer: random and directed stimulus against a per-cycle schedule model
module tb_operand_sequencer;
  localparam int W = 8, C = 4, OW = 9, DW = 2, PW = $clog2(C + 2);
  typedef struct packed {
    logic [OW-1:0] d;
    logic [PW-1:0] ph;
    logic b;
    logic dn;
    logic ov;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int checks = 0, errors = 0;
  exp_t q[$];
  logic ov_hold = 1'b0;
  operand_sequencer_if #(.WIDTH(W), .CHANNELS(C), .OUT_WIDTH(OW)) bus();
  operand_sequencer #(.WIDTH(W), .CHANNELS(C), .OUT_WIDTH(OW), .DWELL(DW)) dut(
    .Clock(clk), .Resetn(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  // whole sequence laid out cycle by cycle from the captured operands
  function automatic void fill(logic [C*W-1:0] din);
    int s = 0;
    for (int i = 0; i < C; i++) begin
      int op = int'(din[i*W +: W]);
      for (int j = 0; j < DW; j++)
        q.push_back('{d: OW'(op), ph: PW'(i + 1), b: 1'b1, dn: 1'b0, ov: s >= (1 << OW)});
      s += op;
    end
    for (int j = 0; j < DW; j++)
      q.push_back('{d: OW'(s), ph: PW'(C + 1), b: 1'b1, dn: j == DW - 1, ov: s >= (1 << OW)});
  endfunction
  task automatic expect_now(string tag);
    exp_t e = q.size() != 0 ? q[0] : '{d: '0, ph: '0, b: 1'b0, dn: 1'b0, ov: ov_hold};
    check({tag, "_data"}, 32'(bus.Data_out), 32'(e.d));
    check({tag, "_phase"}, 32'(bus.Phase), 32'(e.ph));
    check({tag, "_busy"}, 32'(bus.Busy), 32'(e.b));
    check({tag, "_done"}, 32'(bus.Done), 32'(e.dn));
    check({tag, "_ovf"}, 32'(bus.Overflow), 32'(e.ov));
  endtask
  task automatic cycle(string tag);
    bit busy = q.size() != 0;
    if (!rst_n) begin
      q.delete();
      ov_hold = 1'b0;
    end else begin
      if (busy) void'(q.pop_front());
      if (q.size() == 0 && (busy ? bus.Auto : (bus.Start | bus.Auto))) fill(bus.Data_in);
      if (q.size() != 0) ov_hold = q[0].ov;
    end
    @(posedge clk);
    @(negedge clk);
    expect_now(tag);
  endtask
  task automatic pulse_start(logic [C*W-1:0] din, string tag);
    bus.Data_in = din;
    bus.Start = 1'b1;
    cycle(tag);
    bus.Start = 1'b0;
  endtask
  initial begin
    bus.Start = 1'b0;
    bus.Auto = 1'b0;
    bus.Data_in = '0;
    #1 expect_now("reset");
    repeat (2) cycle("reset");
    rst_n = 1'b1;
    cycle("idle");
    pulse_start({8'd40, 8'd30, 8'd20, 8'd10}, "basic");
    check("basic_op0", 32'(bus.Data_out), 32'd10);
    repeat (2 * DW - 1) cycle("basic");
    check("basic_op1", 32'(bus.Data_out), 32'd20);
    repeat (3 * DW + 2) cycle("basic");
    pulse_start({4{8'd255}}, "wrap");
    repeat ((C + 1) * DW - 1) cycle("wrap");
    check("wrap_sum", 32'(bus.Data_out), 32'd508);
    check("wrap_done", 32'(bus.Done), 32'd1);
    repeat (3) cycle("wrap_idle");
    check("wrap_hold", 32'(bus.Overflow), 32'd1);
    pulse_start({8'd1, 8'd2, 8'd3, 8'd4}, "ignore");
    check("ovf_clear", 32'(bus.Overflow), 32'd0);
    cycle("ignore");
    bus.Data_in = {4{8'd99}};
    bus.Start = 1'b1;
    repeat (3) cycle("ignore");
    bus.Start = 1'b0;
    repeat ((C + 1) * DW) cycle("ignore");
    bus.Auto = 1'b1;
    for (int i = 0; i < 4 * (C + 1) * DW; i++) begin
      bus.Data_in = $urandom;
      cycle("auto");
    end
    bus.Data_in = '0;
    bus.Start = 1'b1;
    repeat (3 * (C + 1) * DW) cycle("start_auto");
    bus.Start = 1'b0;
    bus.Auto = 1'b0;
    repeat ((C + 1) * DW + 2) cycle("drain");
    pulse_start({8'd200, 8'd150, 8'd100, 8'd50}, "midrst");
    repeat (2 * DW) cycle("midrst");
    #2 rst_n = 1'b0;
    #1;
    check("rst_data", 32'(bus.Data_out), 32'd0);
    check("rst_phase", 32'(bus.Phase), 32'd0);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_ovf", 32'(bus.Overflow), 32'd0);
    cycle("in_rst");
    rst_n = 1'b1;
    pulse_start({8'd5, 8'd6, 8'd7, 8'd8}, "after_rst");
    repeat ((C + 1) * DW + 1) cycle("after_rst");
    for (int i = 0; i < 600; i++) begin
      bus.Start = $urandom_range(3) == 0;
      if ($urandom_range(15) == 0) bus.Auto = ~bus.Auto;
      bus.Data_in = $urandom;
      rst_n = $urandom_range(79) != 0;
      cycle("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
